vga_timing_gen: RTL and testbench

- Produces the raster scan that the game controller and all pixel renderers consume: hCount, vCount, bright, hSync and vSync for 640x480 at 60 Hz.
- Also produces the slow game clock that advances object positions, derived from frame boundaries.
- Runs from the board clock and uses an internal pixel clock-enable; no second clock domain.
- Sits between the board top level and block_controller / VGA pins.

---
 rtl/vga_timing_pkg.sv | 55 +++++
 rtl/clk_enable_div.sv | 44 ++++
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared constants and helpers for the 640x480 @ 60 Hz raster.
//
// Contents:
//   - Horizontal and vertical timing constants. These are counter positions,
//     with the sync pulse placed at the start of each line and each frame.
//   - vga_decode_t / vga_decode(): the sync and visible-area decode for one
//     (h, v) position.
//   - 12-bit colour constants (4 bits per channel) shared with the renderers.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal timing, in pixels.
  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] H_SYNC_W     = 10'd96;
  localparam logic [9:0] H_DISP_START = 10'd144;
  localparam logic [9:0] H_DISP_END   = 10'd783;

  // Vertical timing, in lines.
  localparam logic [9:0] V_TOTAL      = 10'd525;
  localparam logic [9:0] V_SYNC_W     = 10'd2;
  localparam logic [9:0] V_DISP_START = 10'd35;
  localparam logic [9:0] V_DISP_END   = 10'd514;

  // Colours as {red, green, blue}, 4 bits per channel.
  typedef logic [11:0] rgb12_t;
  localparam rgb12_t COLOR_BLACK  = 12'h000;
  localparam rgb12_t COLOR_WHITE  = 12'hFFF;
  localparam rgb12_t COLOR_RED    = 12'hF00;
  localparam rgb12_t COLOR_GREEN  = 12'h0F0;
  localparam rgb12_t COLOR_BLUE   = 12'h00F;
  localparam rgb12_t COLOR_YELLOW = 12'hFF0;

  // Decoded raster outputs for a single scan position.
  typedef struct packed {
    logic h_sync;  // active low
    logic v_sync;  // active low
    logic bright;  // inside the visible window
  } vga_decode_t;

  // Both sync pulses sit at the start of their period, so (0,0) lies inside
  // both of them.
  function automatic vga_decode_t vga_decode(input logic [9:0] h,
                                             input logic [9:0] v);
    vga_decode_t d;
    d.h_sync = (h >= H_SYNC_W);
    d.v_sync = (v >= V_SYNC_W);
    d.bright = (h >= H_DISP_START) && (h <= H_DISP_END) &&
               (v >= V_DISP_START) && (v <= V_DISP_END);
    return d;
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// -----------------------------------------------------------------------------
// clk_enable_div
//
// Generates a one-clk enable pulse every CLK_DIV clocks. This is used in place
// of a divided clock, so all logic stays in the clk domain.
//
// Parameters:
//   CLK_DIV  clocks per enable pulse, 1..16. With CLK_DIV=1 the enable stays
//            high continuously from the first clk after reset.
//
// Ports:
//   clk  in   clock
//   rst  in   asynchronous, active-high reset
//   en   out  registered enable, high for one clk when the count is CLK_DIV-1
//
// The first enable occurs CLK_DIV clks after reset is released.
// -----------------------------------------------------------------------------
module clk_enable_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic en
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: clocked state uses non-blocking (<=) assignments only. Every flop
  // then samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      en  <= 1'b0;
    end else begin
      en <= (cnt == LAST);
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing for 640x480 @ 60 Hz, driven from the board clock. It uses a
// pixel clock-enable and has no second clock domain. It also generates the
// slow game clock from frame boundaries.
//
// Parameters:
//   CLK_DIV          board clocks per pixel, 1..16 (4: 100 MHz -> 25 MHz)
//   FRAMES_PER_HALF  frames per half-period of game_clk, 1..255
//
// Ports:
//   clk         in   board clock
//   rst         in   asynchronous, active-high reset
//   hCount      out  horizontal pixel counter, 0..799
//   vCount      out  vertical line counter, 0..524
//   bright      out  high inside the visible 640x480 window
//   hSync       out  horizontal sync, active low (hCount < 96)
//   vSync       out  vertical sync, active low (vCount < 2)
//   pix_en      out  one-clk pulse per pixel advance
//   frame_tick  out  one-clk pulse when the scan wraps back to (0,0)
//   game_clk    out  registered square wave; toggles only with frame_tick
//   frame_count out  (only with VGA_FRAME_COUNT_EN) 16-bit frame counter
//
// Optional feature: define VGA_FRAME_COUNT_EN to add frame_count. It counts
// frame_ticks and wraps 65535 -> 0, for debug readout on the seven-segment
// displays.
//
// The sync/bright decodes are registered from the next-state counter values,
// so they line up with hCount/vCount with zero latency.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV         = 4,
  parameter int FRAMES_PER_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        game_clk
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam logic [9:0] H_LAST = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST = V_TOTAL - 10'd1;
  localparam logic [7:0] HALF_LAST = 8'(FRAMES_PER_HALF - 1);

  logic [9:0]  h_cnt, v_cnt;
  logic [9:0]  h_nxt, v_nxt;
  logic        frame_wrap;
  logic [7:0]  half_cnt;
  vga_decode_t dec_nxt;

  // ---------------------------------------------------------------------------
  // Pixel enable
  // ---------------------------------------------------------------------------
  clk_enable_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk (clk),
    .rst (rst),
    .en  (pix_en)
  );

  // ---------------------------------------------------------------------------
  // Next-state counters. When a line wrap and a frame wrap happen on the same
  // pix_en, both are handled together, so (0,525) never appears.
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default first. If any branch
  // left one unassigned, synthesis would infer a latch to hold its old value.
  always_comb begin
    h_nxt      = h_cnt;
    v_nxt      = v_cnt;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        if (v_cnt == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = v_cnt + 10'd1;
        end
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  assign dec_nxt = vga_decode(h_nxt, v_nxt);

  // ---------------------------------------------------------------------------
  // Counters and registered decodes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      hSync      <= dec_nxt.h_sync;
      vSync      <= dec_nxt.v_sync;
      bright     <= dec_nxt.bright;
      frame_tick <= frame_wrap;
    end
  end

  assign hCount = h_cnt;
  assign vCount = v_cnt;

  // ---------------------------------------------------------------------------
  // Game clock: this logic is keyed off frame_wrap, which is the same edge
  // that raises frame_tick. Each game_clk edge therefore coincides with a
  // frame_tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      game_clk <= 1'b0;
    end else if (frame_wrap) begin
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        game_clk <= ~game_clk;
      end else begin
        half_cnt <= half_cnt + 8'd1;
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Debug frame counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_count <= '0;
    else if (frame_wrap) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench with two instances:
//   dut  : CLK_DIV=4, FRAMES_PER_HALF=1 -- reset, divider, line timing,
//          the first frame wrap, and reset asserted mid-frame.
//   dut3 : CLK_DIV=1, FRAMES_PER_HALF=3 -- visible-window edges, vSync width,
//          and the game_clk sequence across several frames.
// Long stretches of the scan are skipped by forcing the counters to a chosen
// position. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst3;
  logic [9:0] h, v, h3, v3;
  logic       br, hs, vs, pe, ft, gc;
  logic       br3, hs3, vs3, pe3, ft3, gc3;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc, fc3;
`endif

  vga_timing_gen #(.CLK_DIV(4), .FRAMES_PER_HALF(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .hCount     (h),
    .vCount     (v),
    .bright     (br),
    .hSync      (hs),
    .vSync      (vs),
    .pix_en     (pe),
    .frame_tick (ft),
    .game_clk   (gc)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count(fc)
`endif
  );

  vga_timing_gen #(.CLK_DIV(1), .FRAMES_PER_HALF(3)) dut3 (
    .clk        (clk),
    .rst        (rst3),
    .hCount     (h3),
    .vCount     (v3),
    .bright     (br3),
    .hSync      (hs3),
    .vSync      (vs3),
    .pix_en     (pe3),
    .frame_tick (ft3),
    .game_clk   (gc3)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count(fc3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Background monitors: the counter range limits, and that game_clk only
  // moves together with frame_tick.
  int   range_viol = 0;
  int   gc_viol    = 0;
  logic gc_prev    = 1'b0;
  logic gc3_prev   = 1'b0;
  always @(negedge clk) begin
    if (h > 10'd799 || v > 10'd524 || h3 > 10'd799 || v3 > 10'd524)
      range_viol <= range_viol + 1;
    if (!rst && gc !== gc_prev && !ft)     gc_viol <= gc_viol + 1;
    if (!rst3 && gc3 !== gc3_prev && !ft3) gc_viol <= gc_viol + 1;
    gc_prev  <= gc;
    gc3_prev <= gc3;
  end

  // Force the scan position; the registers keep the value after release.
  logic [9:0] jh, jv;
  task jump(input logic [9:0] hj, input logic [9:0] vj);
    @(negedge clk);
    jh = hj; jv = vj;
    force dut.h_cnt = jh;
    force dut.v_cnt = jv;
    #1;
    release dut.h_cnt;
    release dut.v_cnt;
  endtask

  task jump3(input logic [9:0] hj, input logic [9:0] vj);
    @(negedge clk);
    jh = hj; jv = vj;
    force dut3.h_cnt = jh;
    force dut3.v_cnt = jv;
    #1;
    release dut3.h_cnt;
    release dut3.v_cnt;
  endtask

  // Count bright samples over one full line of dut3 (one pixel per clk).
  task automatic count_line3(output int b);
    b = 0;
    repeat (800) begin
      @(negedge clk);
      if (br3) b++;
    end
  endtask

  // Jump dut3 near the frame end, then wait (bounded) for frame_tick.
  task automatic tick3(output int n, output int ph, output int pv);
    jump3(10'd795, 10'd524);
    n = 0; ph = 0; pv = 0;
    for (int i = 0; i < 20; i++) begin
      ph = h3; pv = v3;
      @(negedge clk);
      n++;
      if (ft3) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n, ph, pv, ft_seen, b, extra;
  logic gc_exp [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst  = 1'b1;
    rst3 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_hCount", h, 0);
    check("rst_vCount", v, 0);
    check("rst_hSync", hs, 0);
    check("rst_vSync", vs, 0);
    check("rst_bright", br, 0);
    check("rst_pix_en", pe, 0);
    check("rst_frame_tick", ft, 0);
    check("rst_game_clk", gc, 0);
    check("rst3_pix_en", pe3, 0);

    // Release: first pix_en after 4 clks, then every 4 clks.
    rst = 1'b0;
    n = 0; ft_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (ft) ft_seen++;
      if (pe) break;
    end
    check("first_pix_en_clks", n, 4);
    check("h_before_advance", h, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (ft) ft_seen++;
      if (pe) break;
    end
    check("pix_en_period", n, 4);
    check("h_after_first_pix", h, 1);
    check("no_tick_at_reset_exit", ft_seen, 0);

    // Line wrap 799 -> 0 with vCount +1.
    ph = 0; pv = 0;
    for (int i = 0; i < 4000; i++) begin
      ph = h; pv = v;
      @(negedge clk);
      if (v != 10'd0) break;
    end
    check("line_wrap_prev_h", ph, 799);
    check("line_wrap_prev_v", pv, 0);
    check("line_wrap_h", h, 0);
    check("line_wrap_v", v, 1);
    check("vsync_line1", vs, 0);

    // hSync low for 96 pixels = 384 clks.
    n = 0;
    for (int i = 0; i < 500; i++) begin
      if (hs) break;
      n++;
      @(negedge clk);
    end
    check("hsync_low_clks", n, 384);
    check("hsync_rise_h", h, 96);

    // First frame wrap at FRAMES_PER_HALF=1: game_clk toggles with the tick.
    jump(10'd799, 10'd524);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ft) break;
    end
    check("frame_tick_seen", ft, 1);
    check("frame_h", h, 0);
    check("frame_v", v, 0);
    check("game_clk_fph1", gc, 1);
    @(negedge clk);
    check("frame_tick_width", ft, 0);

    // Reset mid-frame at (400,300), held for 2 clks.
    jump(10'd400, 10'd300);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_h", h, 0);
    check("midrst_v", v, 0);
    check("midrst_game_clk", gc, 0);
    check("midrst_frame_tick", ft, 0);
    @(negedge clk);
    check("midrst_h2", h, 0);
    check("midrst_pix_en", pe, 0);
    rst = 1'b0;
    n = 0; ft_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (ft) ft_seen++;
      if (pe) break;
    end
    check("resume_first_pix_en", n, 4);
    @(negedge clk);
    check("resume_h", h, 1);
    check("resume_v", v, 0);
    check("resume_no_tick", ft_seen, 0);

    // dut3: CLK_DIV=1, FRAMES_PER_HALF=3.
    rst3 = 1'b0;
    repeat (3) @(negedge clk);
    check("div1_pix_en_continuous", pe3, 1);

    jump3(10'd799, 10'd33);
    count_line3(b);
    check("bright_line34", b, 0);
    count_line3(b);
    check("bright_line35", b, 640);
    check("after_line35_v", v3, 35);
    check("after_line35_h", h3, 799);

    jump3(10'd799, 10'd513);
    count_line3(b);
    check("bright_line514", b, 640);
    count_line3(b);
    check("bright_line515", b, 0);

    // Seven frame ticks: game_clk changes on the 3rd and 6th.
    for (int k = 0; k < 7; k++) begin
`ifdef VGA_FRAME_COUNT_EN
      if (k == 6) begin
        @(negedge clk);
        force dut3.frame_count = 16'hFFFF;
        #1;
        release dut3.frame_count;
      end
`endif
      tick3(n, ph, pv);
      check($sformatf("tick%0d_seen", k + 1), ft3, 1);
      check($sformatf("tick%0d_game_clk", k + 1), gc3, gc_exp[k]);
      if (k == 0) begin
        check("tick1_latency", n, 5);
        check("tick1_prev_h", ph, 799);
        check("tick1_prev_v", pv, 524);
        check("tick1_h", h3, 0);
        check("tick1_v", v3, 0);
        // vSync low for lines 0 and 1 = 1600 clks at one pixel per clk.
        n = (vs3 == 1'b0) ? 1 : 0;
        extra = 0;
        repeat (1599) begin
          @(negedge clk);
          if (!vs3) n++;
          if (ft3) extra++;
        end
        check("vsync_low_clks", n, 1600);
        check("tick_single_pulse", extra, 0);
        @(negedge clk);
        check("vsync_rise", vs3, 1);
        check("vsync_rise_v", v3, 2);
        check("vsync_rise_h", h3, 0);
      end
`ifdef VGA_FRAME_COUNT_EN
      if (k == 2) check("frame_count_3", fc3, 3);
      if (k == 6) check("frame_count_wrap", fc3, 0);
`endif
    end

    @(negedge clk);
    check("counter_range", range_viol, 0);
    check("game_clk_only_on_tick", gc_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
